// File: rtl/mde_pkg.sv
// Shared types and constants for the market-data engine ingress path.
package mde_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_FLUSH
    } state_t;

    localparam int MDE_NUM_SRC = 4;
    localparam int BYTE_W      = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter import mde_pkg::*; #(
    parameter int NUM_SRC = MDE_NUM_SRC,
    localparam int IDX_W  = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + IDX_W'(1);
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/feed_ingress_arbiter.sv
// Whole-packet round-robin arbiter sharing the engine byte ingress among feed sources;
// a granted source that stalls mid-packet too long is aborted and flushed.
//
// state    | meaning
// ST_IDLE  | no packet owns the ingress; arbitrate among requesting sources
// ST_XFER  | granted source streams bytes to the engine; stall timer running
// ST_FLUSH | packet aborted; granted source drained to its last byte, bytes discarded
module feed_ingress_arbiter import mde_pkg::*; #(
    parameter int NUM_SRC = MDE_NUM_SRC,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = idx_width(NUM_SRC),
    localparam int TMR_W  = $clog2(TIMEOUT)
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic [NUM_SRC*BYTE_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_last,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [BYTE_W-1:0]         udp_data_out,
    output logic                      udp_valid_out,
    output logic                      udp_last_out,
    output logic                      udp_abort_out,
    input  logic                      udp_ready_in,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          pkt_count,
    output logic [CNT_W-1:0]          abort_count
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_SRC-1:0]  grant_oh;
    logic [TMR_W-1:0]    idle_left;

    logic [NUM_SRC-1:0]  arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;

    logic [BYTE_W-1:0]   g_data;
    logic                g_valid;
    logic                g_last;
    logic                timer_exp;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr_arbiter (
        .req       (src_valid),
        .ptr       (rr_ptr),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == IDX_W'(i)) begin
                g_data  = src_data[i*BYTE_W +: BYTE_W];
                g_valid = src_valid[i];
                g_last  = src_last[i];
            end
        end
    end

    // Expiry is the cycle the timer sits at zero with the source still idle.
    assign timer_exp = (state == ST_XFER) && !g_valid && (idle_left == '0);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        udp_data_out  = '0;
        udp_valid_out = 1'b0;
        udp_last_out  = 1'b0;
        udp_abort_out = 1'b0;
        src_ready     = '0;
        case (state)
            ST_XFER: begin
                udp_data_out  = g_data;
                udp_valid_out = g_valid;
                udp_last_out  = g_valid & g_last;
                udp_abort_out = timer_exp;
                src_ready     = grant_oh & {NUM_SRC{udp_ready_in}};
            end
            ST_FLUSH: src_ready = grant_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            grant_oh    <= '0;
            rr_ptr      <= IDX_W'(NUM_SRC - 1);
            idle_left   <= TMR_LOAD;
            pkt_count   <= '0;
            abort_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_id  <= arb_idx;
                        grant_oh  <= arb_oh;
                        rr_ptr    <= arb_idx;
                        idle_left <= TMR_LOAD;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (g_valid) begin
                        idle_left <= TMR_LOAD;
                        if (udp_ready_in && g_last) begin
                            pkt_count <= pkt_count + CNT_W'(1);
                            state     <= ST_IDLE;
                        end
                    end else if (idle_left == '0) begin
                        abort_count <= abort_count + CNT_W'(1);
                        state       <= ST_FLUSH;
                    end else begin
                        idle_left <= idle_left - TMR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (g_valid && g_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feed_ingress_arbiter.sv
// Scoreboard bench for feed_ingress_arbiter: per-source packet queues drive the sources,
// expected engine-side beats and abort markers are queued per source and checked by a monitor.
module tb_feed_ingress_arbiter;
    parameter int N_SRC = 4;
    localparam int TMO = 16;
    localparam int CW  = 32;
    localparam int IW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic [15:0] gap;
        logic        last;
        logic [7:0]  data;
    } beat_t;

    logic                 clk_sys = 1'b0;
    logic                 rst;
    logic [N_SRC*8-1:0]   src_data;
    logic [N_SRC-1:0]     src_valid;
    logic [N_SRC-1:0]     src_last;
    logic [N_SRC-1:0]     src_ready;
    logic [7:0]           udp_data_out;
    logic                 udp_valid_out;
    logic                 udp_last_out;
    logic                 udp_abort_out;
    logic                 udp_ready_in;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic [CW-1:0]        pkt_count;
    logic [CW-1:0]        abort_count;

    always #5 clk_sys = ~clk_sys;

    feed_ingress_arbiter #(.NUM_SRC(N_SRC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .udp_data_out  (udp_data_out),
        .udp_valid_out (udp_valid_out),
        .udp_last_out  (udp_last_out),
        .udp_abort_out (udp_abort_out),
        .udp_ready_in  (udp_ready_in),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .abort_count   (abort_count)
    );

    int total = 0;
    int bad   = 0;
    beat_t        sq[N_SRC][$];
    logic [9:0]   exp_b[N_SRC][$];
    logic [IW-1:0] grant_log[$];
    int ready_mode = 0;
    int m_pkts = 0;
    int m_aborts = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Queue a packet; gaps are idle cycles before each byte. Any non-first gap of
    // TMO or more truncates the packet there: the engine sees the prefix then an abort.
    task automatic send_pkt(input int src, input int len, input int gap_first,
                            input int big_at, input int big_gap, input int sg_max);
        int cut = -1;
        for (int k = 0; k < len; k++) begin
            beat_t b;
            int g;
            g = (k == 0) ? gap_first : ((k == big_at) ? big_gap : int'($urandom_range(0, sg_max)));
            b.gap  = 16'(g);
            b.last = (k == len - 1);
            b.data = 8'($urandom);
            sq[src].push_back(b);
            if (k > 0 && g >= TMO && cut < 0) cut = k;
            if (cut < 0) exp_b[src].push_back({1'b0, b.last, b.data});
        end
        if (cut >= 0) exp_b[src].push_back(10'h200);
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #2;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N_SRC; i++)
            if (sq[i].size() != 0 || exp_b[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 5000) begin
            tick();
            n++;
            done = all_empty() && !busy;
        end
        check({nm, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic wait_grant(input int g, input string nm);
        int n = 0;
        while (!busy && n < 2000) begin
            tick();
            n++;
        end
        check({nm, "_busy"}, 64'(busy), 64'd1);
        check({nm, "_grant"}, 64'(grant_id), 64'(g));
    endtask

    // Source drivers: hold each byte valid until accepted; honour per-byte idle gaps.
    logic [N_SRC-1:0] fire_s;
    bit loaded[N_SRC];
    int wait_left[N_SRC];
    initial begin
        src_valid    = '0;
        src_data     = '0;
        src_last     = '0;
        udp_ready_in = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            loaded[i] = 1'b0;
            wait_left[i] = 0;
        end
        forever begin
            @(negedge clk_sys);
            fire_s = src_valid & src_ready;
            @(posedge clk_sys);
            #1;
            for (int i = 0; i < N_SRC; i++) begin
                if (rst) begin
                    loaded[i] = 1'b0;
                    src_valid[i] = 1'b0;
                    src_last[i] = 1'b0;
                    continue;
                end
                if (fire_s[i] && sq[i].size() > 0) begin
                    void'(sq[i].pop_front());
                    loaded[i] = 1'b0;
                end
                if (sq[i].size() == 0) begin
                    src_valid[i] = 1'b0;
                    src_last[i] = 1'b0;
                    src_data[i*8 +: 8] = 8'h00;
                end else begin
                    beat_t b;
                    b = sq[i][0];
                    if (!loaded[i]) begin
                        wait_left[i] = int'(b.gap);
                        loaded[i] = 1'b1;
                    end
                    if (wait_left[i] > 0) begin
                        src_valid[i] = 1'b0;
                        src_last[i] = 1'b0;
                        wait_left[i]--;
                    end else begin
                        src_valid[i] = 1'b1;
                        src_last[i] = b.last;
                        src_data[i*8 +: 8] = b.data;
                    end
                end
            end
            case (ready_mode)
                0: udp_ready_in = 1'b1;
                1: udp_ready_in = ($urandom_range(0, 9) < 7);
                default: udp_ready_in = 1'b0;
            endcase
        end
    end

    // Monitor: independent round-robin model plus per-source scoreboard.
    initial begin
        int last_g, exp_g, cur_g;
        bit pend, flushing;
        logic [9:0] e;
        logic [N_SRC-1:0] oh;
        last_g = N_SRC - 1;
        cur_g = 0;
        exp_g = 0;
        pend = 1'b0;
        flushing = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (rst) begin
                last_g = N_SRC - 1;
                pend = 1'b0;
                flushing = 1'b0;
                m_pkts = 0;
                m_aborts = 0;
                continue;
            end
            check("pkt_count", 64'(pkt_count), 64'(m_pkts));
            check("abort_count", 64'(abort_count), 64'(m_aborts));
            if (pend) begin
                check("rr_grant", 64'(grant_id), 64'(exp_g));
                check("rr_busy", 64'(busy), 64'd1);
                grant_log.push_back(grant_id);
                pend = 1'b0;
            end
            if (!busy) begin
                check("idle_ready", 64'(src_ready), 64'd0);
                check("idle_valid", 64'(udp_valid_out), 64'd0);
                if (src_valid != '0) begin
                    for (int k = N_SRC; k >= 1; k--)
                        if (src_valid[(last_g + k) % N_SRC]) exp_g = (last_g + k) % N_SRC;
                    last_g = exp_g;
                    cur_g = exp_g;
                    pend = 1'b1;
                end
            end else begin
                oh = '0;
                oh[cur_g] = 1'b1;
                check("foreign_ready", 64'(src_ready & ~oh), 64'd0);
                if (udp_valid_out && udp_ready_in) begin
                    check("beat_expected", 64'(exp_b[cur_g].size() > 0), 64'd1);
                    if (exp_b[cur_g].size() > 0) begin
                        e = exp_b[cur_g].pop_front();
                        check("beat", 64'({1'b0, udp_last_out, udp_data_out}), 64'(e));
                        if (e[8]) m_pkts++;
                    end
                end
                if (udp_abort_out) begin
                    check("abort_expected", 64'(exp_b[cur_g].size() > 0), 64'd1);
                    if (exp_b[cur_g].size() > 0) begin
                        e = exp_b[cur_g].pop_front();
                        check("abort_marker", 64'(e[9]), 64'd1);
                        if (e[9]) m_aborts++;
                    end
                    flushing = 1'b1;
                end else if (flushing) begin
                    check("flush_quiet", 64'(udp_valid_out), 64'd0);
                    if (src_valid[cur_g] && src_ready[cur_g] && src_last[cur_g]) flushing = 1'b0;
                end
            end
        end
    end

    initial begin
        int s1, s2, s3, n;
        s1 = 1 % N_SRC;
        s2 = 2 % N_SRC;
        s3 = 3 % N_SRC;
        rst = 1'b1;
        repeat (3) @(negedge clk_sys);
        #2;
        rst = 1'b0;

        // Round-robin fairness: every source has back-to-back 4-byte packets.
        for (int s = 0; s < N_SRC; s++)
            for (int p = 0; p < 8 / N_SRC; p++) send_pkt(s, 4, 0, -1, 0, 0);
        drain("fair");
        check("fair_log_len", 64'(grant_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("fair_seq", 64'(grant_log[k]), 64'(k % N_SRC));
        check("fair_pkt_count", 64'(pkt_count), 64'd8);

        // Long engine backpressure mid-packet must never count as a stall.
        send_pkt(s2, 5, 0, -1, 0, 0);
        wait_grant(s2, "bp");
        tick();
        tick();
        ready_mode = 2;
        repeat (500) tick();
        ready_mode = 0;
        drain("bp");
        check("bp_abort_count", 64'(abort_count), 64'd0);

        // Stall of TMO idle cycles after two bytes: abort, flush, then next source.
        send_pkt(s1, 5, 0, 2, TMO, 0);
        wait_grant(s1, "tmo");
        send_pkt(s3, 3, 0, -1, 0, 0);
        drain("tmo");
        check("tmo_abort_count", 64'(abort_count), 64'd1);
        check("tmo_next_grant", 64'(grant_log[grant_log.size() - 1]), 64'(s3));

        // Valid returning exactly on the expiry cycle wins.
        send_pkt(0, 4, 0, 2, TMO - 1, 0);
        drain("edge");
        check("edge_abort_count", 64'(abort_count), 64'd1);

        // Single-byte packet, then exactly one IDLE cycle before the waiting source.
        send_pkt(0, 1, 0, -1, 0, 0);
        wait_grant(0, "one");
        send_pkt(s1, 3, 0, -1, 0, 0);
        n = 0;
        while (!(udp_valid_out && udp_ready_in && udp_last_out) && n < 100) begin
            tick();
            n++;
        end
        check("one_last_seen", 64'(udp_valid_out && udp_last_out), 64'd1);
        tick();
        check("one_idle_gap", 64'(busy), 64'd0);
        tick();
        check("one_regrant_busy", 64'(busy), 64'd1);
        check("one_regrant_id", 64'(grant_id), 64'(s1));
        drain("one");

        // Reset in the middle of a packet.
        send_pkt(s1, 6, 0, -1, 0, 0);
        wait_grant(s1, "rst");
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(udp_valid_out), 64'd0);
        check("rst_data", 64'(udp_data_out), 64'd0);
        check("rst_last", 64'(udp_last_out), 64'd0);
        check("rst_abort", 64'(udp_abort_out), 64'd0);
        check("rst_ready", 64'(src_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_abort_count", 64'(abort_count), 64'd0);
        for (int i = 0; i < N_SRC; i++) begin
            sq[i].delete();
            exp_b[i].delete();
        end
        tick();
        tick();
        rst = 1'b0;
        send_pkt(s1, 3, 0, -1, 0, 0);
        send_pkt(0, 3, 0, -1, 0, 0);
        wait_grant(0, "rst_first");
        drain("rst");

        // Randomised traffic with random engine readiness and occasional stalls.
        ready_mode = 1;
        for (int burst = 0; burst < 4; burst++) begin
            for (int p = 0; p < 15; p++) begin
                int src, len, big_at, big_gap;
                src = int'($urandom_range(0, N_SRC - 1));
                len = int'($urandom_range(1, 6));
                big_at = -1;
                big_gap = 0;
                if (len > 1 && $urandom_range(0, 4) == 0) begin
                    big_at = int'($urandom_range(1, len - 1));
                    big_gap = ($urandom_range(0, 1) == 0) ? TMO - 1 : TMO + int'($urandom_range(0, 3));
                end
                send_pkt(src, len, int'($urandom_range(0, 3)), big_at, big_gap, 3);
            end
            drain("rand");
        end
        ready_mode = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
